// File: rtl/sys_bus_interconnect.sv
// Purpose: decodes one CPU data access to one of NSLAVES targets, forwards it and returns data/ready/error.
// Latency: decode miss 1 cycle, hit 2 + slave wait cycles, timeout TIMEOUT+1 cycles after the request edge.
// Backpressure: a single outstanding access; requests are sampled only in IDLE, slaves stall through s_ready.
module sys_bus_interconnect #(
    parameter int                      NSLAVES    = 3,
    parameter logic [NSLAVES*32-1:0]   SLAVE_BASE = {32'h10001000, 32'h10000000, 32'h00000000},
    parameter logic [NSLAVES*32-1:0]   SLAVE_MASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000},
    parameter int                      TIMEOUT    = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_res,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_mask,
    input  logic                    m_we,
    input  logic                    m_re,
    output logic [31:0]             m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [NSLAVES-1:0]      s_sel,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_mask,
    output logic                    s_we,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    input  logic [NSLAVES-1:0]      s_ready
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NSLAVES-1:0]  hit_oh;
    logic                hit;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    // Priority decode: the first matching slot wins when regions overlap.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (!hit && ((m_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32])) begin
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Only the currently selected slave can complete the access or supply data.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (s_sel[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*32 +: 32];
            end
        end
    end

    assign sel_ready = |(s_sel & s_ready);

    always_ff @(posedge sys_clk) begin
        if (!sys_res) begin
            state   <= IDLE;
            cnt     <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            s_sel   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_mask  <= '0;
            s_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    if (m_we || m_re) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_mask  <= m_mask;
                        s_we    <= m_we;
                        cnt     <= '0;
                        if (hit) begin
                            s_sel <= hit_oh;
                            state <= ACCESS;
                        end else begin
                            m_rdata <= '0;
                            m_err   <= 1'b1;
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // A ready arriving in the final allowed cycle still completes normally.
                    if (sel_ready) begin
                        m_rdata <= s_we ? 32'h0 : sel_rdata;
                        m_err   <= 1'b0;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        state   <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Scoreboarded bench: stimulus pushes expected responses, a monitor checks bus activity and completions.
module tb_sys_bus_interconnect;

    localparam int NS = 3;
    localparam int TO = 16;
    localparam logic [31:0] BASE [NS] = '{32'h00000000, 32'h10000000, 32'h10001000};
    localparam logic [31:0] MASK [NS] = '{32'hFFFF0000, 32'hFFFFF000, 32'hFFFFF000};

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            req_cyc;
        logic [NS-1:0] sel;
        int            sel_cycles;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    mask;
    } exp_t;

    logic               sys_clk = 1'b0;
    logic               sys_res = 1'b0;
    logic [31:0]        m_addr  = '0;
    logic [31:0]        m_wdata = '0;
    logic [3:0]         m_mask  = '0;
    logic               m_we    = 1'b0;
    logic               m_re    = 1'b0;
    logic [31:0]        m_rdata;
    logic               m_ready;
    logic               m_err;
    logic [NS-1:0]      s_sel;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;
    logic [3:0]         s_mask;
    logic               s_we;
    logic [NS*32-1:0]   s_rdata = '0;
    logic [NS-1:0]      s_ready = '0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    exp_t        exp_q [$];
    int          sel_cnt = 0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_rdata = '0;

    // Slave behaviour for the current transaction: target index, ACCESS cycle of ready (0 = never).
    int          plan_tgt  = -1;
    int          plan_cyc  = 0;
    logic [31:0] plan_data = '0;
    bit          plan_spur = 1'b0;
    int          acc_cyc   = 0;

    sys_bus_interconnect #(
        .NSLAVES    (NS),
        .SLAVE_BASE ({BASE[2], BASE[1], BASE[0]}),
        .SLAVE_MASK ({MASK[2], MASK[1], MASK[0]}),
        .TIMEOUT    (TO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_res (sys_res),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_mask  (m_mask),
        .m_we    (m_we),
        .m_re    (m_re),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_sel   (s_sel),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_mask  (s_mask),
        .s_we    (s_we),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    // Slave models: the target raises ready in its planned ACCESS cycle; others may raise spurious ready.
    always @(negedge sys_clk) begin
        logic [NS-1:0]    rdy;
        logic [NS*32-1:0] rd;
        if (s_sel != '0) acc_cyc = acc_cyc + 1;
        else             acc_cyc = 0;
        rdy = '0;
        for (int j = 0; j < NS; j++) rd[j*32 +: 32] = $urandom;
        if (plan_spur) rdy = '1;
        if (plan_tgt >= 0) begin
            rdy[plan_tgt] = (acc_cyc != 0) && (acc_cyc == plan_cyc);
            rd[plan_tgt*32 +: 32] = plan_data;
        end
        s_ready = rdy;
        s_rdata = rd;
    end

    // Monitor: checks the broadcast bus while a slave is selected and every master response.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_res) begin
            prev_ready = 1'b0;
        end else begin
            if (prev_ready) begin
                check("pulse_m_ready", m_ready, 1'b0);
                check("pulse_m_err",   m_err,   1'b0);
                check("hold_m_rdata",  m_rdata, prev_rdata);
            end
            prev_ready = m_ready;
            prev_rdata = m_rdata;
            if (s_sel != '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sel_idle: s_sel=%b with no transaction outstanding", s_sel);
                end else begin
                    e = exp_q[0];
                    check("s_sel",   s_sel,   e.sel);
                    check("s_addr",  s_addr,  e.addr);
                    check("s_wdata", s_wdata, e.wdata);
                    check("s_mask",  s_mask,  e.mask);
                    check("s_we",    s_we,    e.we);
                    sel_cnt++;
                end
            end
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: m_ready=1 with no transaction outstanding");
                end else begin
                    e = exp_q.pop_front();
                    check("m_rdata",    m_rdata, e.rdata);
                    check("m_err",      m_err,   e.err);
                    check("latency",    32'(cyc - e.req_cyc + 1), 32'(e.lat));
                    check("sel_cycles", 32'(sel_cnt), 32'(e.sel_cycles));
                end
                sel_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at a negedge where the next request may be driven.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mk,
                         input logic we, input logic re, input int rc, input logic [31:0] dat,
                         input bit spur, input int gap);
        exp_t e;
        int   t;
        bit   got;
        t = decode(a);
        plan_tgt  = t;
        plan_cyc  = rc;
        plan_data = dat;
        plan_spur = spur;
        e.we = we; e.addr = a; e.wdata = wd; e.mask = mk; e.req_cyc = cyc + 1;
        if (t < 0) begin
            e.sel = '0; e.err = 1'b1; e.rdata = '0; e.lat = 1; e.sel_cycles = 0;
        end else if (rc >= 1 && rc <= TO) begin
            e.sel = NS'(1) << t; e.err = 1'b0; e.rdata = we ? 32'h0 : dat;
            e.lat = rc + 1; e.sel_cycles = rc;
        end else begin
            e.sel = NS'(1) << t; e.err = 1'b1; e.rdata = '0; e.lat = TO + 1; e.sel_cycles = TO;
        end
        exp_q.push_back(e);
        m_addr = a; m_wdata = wd; m_mask = mk; m_we = we; m_re = re;
        got = 1'b0;
        for (int k = 0; k < TO + 8 && !got; k++) begin
            @(negedge sys_clk);
            got = m_ready;
        end
        check("response_seen", got, 1'b1);
        if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge sys_clk);
        if (gap > 0) begin
            m_we = 1'b0;
            m_re = 1'b0;
            repeat (gap) @(negedge sys_clk);
        end
    endtask

    task automatic reset_mid_access();
        exp_t e;
        bit   seen;
        plan_tgt = 1; plan_cyc = 0; plan_spur = 1'b0;
        e.we = 1'b0; e.addr = 32'h10000020; e.wdata = 32'h0; e.mask = 4'hF;
        e.req_cyc = cyc + 1; e.sel = 3'b010; e.err = 1'b1; e.rdata = '0; e.lat = 0; e.sel_cycles = 0;
        exp_q.push_back(e);
        m_addr = e.addr; m_wdata = 32'h0; m_mask = 4'hF; m_we = 1'b0; m_re = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("mid_sel_active", s_sel, 3'b010);
        sys_res = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_s_sel",   s_sel,   3'b000);
        check("mid_rst_m_ready", m_ready, 1'b0);
        m_re = 1'b0;
        void'(exp_q.pop_front());
        sel_cnt = 0;
        @(negedge sys_clk);
        sys_res = 1'b1;
        seen = 1'b0;
        repeat (TO + 4) begin
            @(negedge sys_clk);
            seen = seen | m_ready | (s_sel != '0);
        end
        check("dropped_no_activity", seen, 1'b0);
    endtask

    initial begin
        int          r;
        int          k;
        int          rc;
        logic [31:0] a;
        sys_res = 1'b0;
        m_re = 1'b1; m_addr = 32'h00000040; m_wdata = 32'h0; m_mask = 4'h0;
        plan_tgt = 0; plan_cyc = 1; plan_data = 32'hDEADBEEF;
        @(posedge sys_clk);
        repeat (3) begin
            @(negedge sys_clk);
            check("rst_m_ready", m_ready, 1'b0);
            check("rst_m_err",   m_err,   1'b0);
            check("rst_s_sel",   s_sel,   3'b000);
            check("rst_m_rdata", m_rdata, 32'h0);
            check("rst_s_we",    s_we,    1'b0);
            check("rst_s_addr",  s_addr,  32'h0);
        end
        sys_res = 1'b1;
        issue(32'h00000040, 32'h0,        4'h0,    1'b0, 1'b1, 1,  32'hDEADBEEF, 1'b0, 1);
        issue(32'h10001008, 32'h12345678, 4'b0011, 1'b1, 1'b0, 3,  32'h55AA55AA, 1'b0, 1);
        issue(32'h20000000, 32'h0,        4'h0,    1'b0, 1'b1, 1,  32'h11111111, 1'b0, 1);
        issue(32'h10000004, 32'h0,        4'h0,    1'b0, 1'b1, 0,  32'h22222222, 1'b0, 1);
        issue(32'h10000004, 32'h0,        4'h0,    1'b0, 1'b1, TO, 32'hA5A5A5A5, 1'b0, 0);
        issue(32'h10000010, 32'h0,        4'h0,    1'b0, 1'b1, 4,  32'h0BADF00D, 1'b1, 0);
        issue(32'h00000044, 32'hCAFEF00D, 4'hF,    1'b1, 1'b1, 2,  32'hFFFFFFFF, 1'b0, 1);
        reset_mid_access();
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      a = {16'h0000, 16'($urandom)};
            else if (r <= 4) a = 32'h10000000 | ($urandom & 32'h00000FFF);
            else if (r <= 6) a = 32'h10001000 | ($urandom & 32'h00000FFF);
            else             a = $urandom;
            k  = $urandom_range(0, 2);
            rc = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 5);
            issue(a, $urandom, 4'($urandom), k != 0, k != 1, rc, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        end
        repeat (3) @(negedge sys_clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
